mux_scan_ctrl: RTL and testbench
================================

// Module: mux_scan_ctrl
// PURPOSE
//  Scan controller for the 10x1 selector stage. Accepts a 10-bit word by valid/ready,
//  drives it onto the mux data bus and sweeps the select 0..N-1 one step per clock.
//  Each cycle it samples the mux output, rebuilds the word and presents it downstream
//  by valid/ready. It drives mux_i/mux_s upstream of the mux and consumes mux_y.
// PARAMETERS
//  N   10  mux data inputs / word width (2..2**SW)
//  SW  4   select width
// PORTS
//  clk        in   1   single clock, rising edge
//  rst_n      in   1   asynchronous, active-low reset
//  in_valid   in   1   input word valid
//  in_ready   out  1   controller can accept a word
//  in_data    in   N   word to scan
//  mux_i      out  N   mux data bus (latched word)
//  mux_s      out  SW  mux select
//  mux_y      in   1   mux output, combinational from mux_i/mux_s
//  out_valid  out  1   reconstructed word valid
//  out_ready  in   1   downstream accepts word
//  out_data   out  N   reconstructed word, bit k = mux_y sampled at mux_s==k
//  busy       out  1   high in SCAN/CHK
//  oor_err    out  1   out-of-range check failed (MUX_SCAN_OOR_CHECK_EN only; else tied 0)
// BEHAVIOUR
//  Reset (async): state=IDLE; mux_i=0, mux_s=0, out_data=0, out_valid=0, busy=0,
//   oor_err=0, in_ready=1. rst_n low mid-scan aborts at once; partial word discarded.
//  Control is an FSM with states IDLE, SCAN, CHK and DONE.
//  IDLE: in_ready=1, mux_s=0. On in_valid&&in_ready, mux_i<=in_data, cap<=0,
//   mux_s<=0 and the FSM goes to SCAN.
//  SCAN: mux_s=k. At each edge cap[k]<=mux_y. If k==N-1, go to DONE, or to CHK with the
//   macro. Otherwise mux_s<=k+1.
//  CHK (macro only): mux_s steps N..2**SW-1. At each edge sticky_err |= mux_y.
//   After 2**SW-1 the FSM goes to DONE.
//  DONE: out_valid=1, out_data=cap held stable until out_ready. Then the FSM returns to
//   IDLE, mux_s<=0, and out_valid drops on the next cycle.
//  Handshake: transfer happens when valid&&ready at a rising edge. in_ready=0 outside IDLE.
//   in_valid during SCAN/CHK/DONE is ignored, and the source must hold it.
//   The controller does not accept a new word in the same cycle as an out handshake.
//  Latency: in handshake at edge t; out_valid high from edge t+N (t+2**SW with macro).
//  Width rules: mux_s never exceeds N-1 without the macro. The counter is SW bits and
//   never wraps; the terminal compare is against N-1 (or 2**SW-1).
//  mux_i is stable for the whole scan and changes only at an in handshake.
//  oor_err updates on entry to DONE and holds until the next in handshake clears it.
// CONFIGURATION
//  `MUX_SCAN_OOR_CHECK_EN defined: CHK state is present. Selects N..2**SW-1 are
//   driven and mux_y must read 0 there, otherwise oor_err=1 with that word.
//  Macro undefined: CHK is removed, SCAN goes straight to DONE and oor_err is tied 0.
// STRUCTURE
//  Package mux_scan_pkg: state encoding localparams (IDLE/SCAN/CHK/DONE), defaults N/SW.
//  The FSM and select counter sit in sub-module mux_scan_fsm (outputs state, sel, load,
//   capture_en). The top holds the data/capture registers and handshake logic.
//  The 10x1 mux is instantiated externally and is not part of this block.
// TESTING (bench instantiates mux_scan_ctrl + mux_10x1 in loopback)
//  1 in_data=10'b1010101011, out_ready=1 -> out_valid after 10 cycles,
//    out_data=10'b1010101011, mux_s observed 0..9.
//  2 in_data=10'h3FF, then 10'h000 back-to-back, out_ready low 5 cycles -> out_valid and
//    out_data=3FF are held, in_ready=0 throughout, then 000 is returned.
//  3 rst_n low at mux_s=4 during scan of 10'h155 -> all outputs at reset values
//    immediately. The next word 10'h2AA returns exactly 2AA.
//  4 in_valid pulsed while busy with in_data=10'h0F0 -> ignored. The first word
//    10'h00F is returned unchanged.
//  5 macro on, good mux -> mux_s sweeps 0..15, oor_err=0. Faulty mux model returns 1 at
//    s=12 -> oor_err=1, out_data still correct.
//  6 macro off -> mux_s never >9 over 100 random words. Every out_data equals its
//    in_data.

Source files
------------

// File: rtl/mux_scan_pkg.sv
// Shared types and defaults for the 10x1 selector scan controller.
// Contents: default word width / select width and the controller state encoding.
package mux_scan_pkg;

  localparam int unsigned N_DEF  = 10;
  localparam int unsigned SW_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_CHK  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

endpackage : mux_scan_pkg

// File: rtl/mux_scan_ctrl_if.sv
// Bus bundle between the scan controller, its word source/sink and the external mux.
// Signals: in_valid/in_ready/in_data (word in), out_valid/out_ready/out_data (word out),
//          mux_i/mux_s (driven to the mux), mux_y (mux output back to the controller).
// master: controller side.  slave: source/sink/mux side.
interface mux_scan_ctrl_if
  import mux_scan_pkg::*;
#(
  parameter int unsigned N  = N_DEF,
  parameter int unsigned SW = SW_DEF
) ();

  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  in_data;
  logic          out_valid;
  logic          out_ready;
  logic [N-1:0]  out_data;
  logic [N-1:0]  mux_i;
  logic [SW-1:0] mux_s;
  logic          mux_y;

  modport master (
    input  in_valid, in_data, out_ready, mux_y,
    output in_ready, out_valid, out_data, mux_i, mux_s
  );

  modport slave (
    output in_valid, in_data, out_ready, mux_y,
    input  in_ready, out_valid, out_data, mux_i, mux_s
  );

endinterface : mux_scan_ctrl_if

// File: rtl/mux_scan_fsm.sv
// Control FSM and select counter for the scan controller.
// Ports: clk, rst_n (async, active-low); in_valid_i, out_ready_i (handshake inputs);
//        state_o (registered state), sel_o (registered mux select),
//        load_c_o (word accepted this cycle), capture_c_o (sample mux_y this cycle).
// Optional: MUX_SCAN_OOR_CHECK_EN adds the CHK sweep over selects N..2**SW-1.
module mux_scan_fsm
  import mux_scan_pkg::*;
#(
  parameter int unsigned N  = N_DEF,
  parameter int unsigned SW = SW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid_i,
  input  logic          out_ready_i,
  output state_e        state_o,
  output logic [SW-1:0] sel_o,
  output logic          load_c_o,
  output logic          capture_c_o
);

  localparam logic [SW-1:0] SEL_LAST = SW'(N - 1);
`ifdef MUX_SCAN_OOR_CHECK_EN
  localparam logic [SW-1:0] SEL_MAX  = {SW{1'b1}};
`endif

  state_e        state_q, state_d;
  logic [SW-1:0] sel_q, sel_d;

  // State and select registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
    end
  end

  // Next-state, select stepping and strobes
  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    load_c_o    = 1'b0;
    capture_c_o = 1'b0;
    case (state_q)
      ST_IDLE: begin
        sel_d = '0;
        if (in_valid_i) begin
          load_c_o = 1'b1;
          state_d  = ST_SCAN;
        end
      end
      ST_SCAN: begin
        capture_c_o = 1'b1;
        if (sel_q == SEL_LAST) begin
`ifdef MUX_SCAN_OOR_CHECK_EN
          state_d = ST_CHK;
          sel_d   = sel_q + SW'(1);
`else
          // Select holds at N-1 through DONE so it never leaves the legal range.
          state_d = ST_DONE;
`endif
        end else begin
          sel_d = sel_q + SW'(1);
        end
      end
      ST_CHK: begin
`ifdef MUX_SCAN_OOR_CHECK_EN
        if (sel_q == SEL_MAX) begin
          state_d = ST_DONE;
        end else begin
          sel_d = sel_q + SW'(1);
        end
`else
        // Unreachable without the range check; recover to idle.
        state_d = ST_IDLE;
        sel_d   = '0;
`endif
      end
      ST_DONE: begin
        if (out_ready_i) begin
          state_d = ST_IDLE;
          sel_d   = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        sel_d   = '0;
      end
    endcase
  end

  assign state_o = state_q;
  assign sel_o   = sel_q;

endmodule : mux_scan_fsm

// File: rtl/mux_scan_ctrl.sv
// Scan controller for the 10x1 selector stage: accepts a word, drives it onto the mux
// data bus, sweeps the select one step per clock, rebuilds the word from mux_y and
// hands it downstream.
// Ports: clk, rst_n (async, active-low); bus (mux_scan_ctrl_if.master: in/out
//        valid-ready word channels plus mux_i/mux_s/mux_y); busy (scan or check in
//        progress); oor_err (a select >= N read back 1 for the last word).
// Optional: MUX_SCAN_OOR_CHECK_EN enables the out-of-range sweep; otherwise oor_err=0.
module mux_scan_ctrl
  import mux_scan_pkg::*;
#(
  parameter int unsigned N  = N_DEF,
  parameter int unsigned SW = SW_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  mux_scan_ctrl_if.master  bus,
  output logic             busy,
  output logic             oor_err
);

  localparam logic [SW-1:0] SEL_LAST = SW'(N - 1);
`ifdef MUX_SCAN_OOR_CHECK_EN
  localparam logic [SW-1:0] SEL_MAX  = {SW{1'b1}};
`endif

  state_e        state;
  logic [SW-1:0] sel;
  logic          load_c;
  logic          capture_c;
  logic          done_entry_c;
  logic          out_hs_c;

  logic [N-1:0]  mux_i_q, mux_i_d;
  logic [N-1:0]  cap_q, cap_d;
  logic          out_valid_q, out_valid_d;
  logic          in_ready_q, in_ready_d;
  logic          busy_q, busy_d;
`ifdef MUX_SCAN_OOR_CHECK_EN
  logic          sticky_q, sticky_d;
  logic          oor_q, oor_d;
`endif

  mux_scan_fsm #(
    .N  (N),
    .SW (SW)
  ) u_fsm (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid_i  (bus.in_valid),
    .out_ready_i (bus.out_ready),
    .state_o     (state),
    .sel_o       (sel),
    .load_c_o    (load_c),
    .capture_c_o (capture_c)
  );

  // The edge that moves the FSM into DONE: last scan step, or last check step.
`ifdef MUX_SCAN_OOR_CHECK_EN
  assign done_entry_c = (state == ST_CHK) && (sel == SEL_MAX);
`else
  assign done_entry_c = (state == ST_SCAN) && (sel == SEL_LAST);
`endif
  assign out_hs_c = out_valid_q & bus.out_ready;

  // Data, capture and handshake next-state
  always_comb begin
    mux_i_d     = mux_i_q;
    cap_d       = cap_q;
    out_valid_d = out_valid_q;
    in_ready_d  = in_ready_q;
    busy_d      = busy_q;
`ifdef MUX_SCAN_OOR_CHECK_EN
    sticky_d    = sticky_q;
    oor_d       = oor_q;
`endif
    if (load_c) begin
      mux_i_d    = bus.in_data;
      cap_d      = '0;
      in_ready_d = 1'b0;
      busy_d     = 1'b1;
`ifdef MUX_SCAN_OOR_CHECK_EN
      sticky_d   = 1'b0;
      oor_d      = 1'b0;
`endif
    end
    if (capture_c) begin
      for (int unsigned k = 0; k < N; k++) begin
        if (sel == SW'(k)) cap_d[k] = bus.mux_y;
      end
    end
`ifdef MUX_SCAN_OOR_CHECK_EN
    if (state == ST_CHK) sticky_d = sticky_q | bus.mux_y;
    // Fold in the final check sample, taken on the same edge that enters DONE.
    if (done_entry_c) oor_d = sticky_q | bus.mux_y;
`endif
    if (done_entry_c) begin
      busy_d      = 1'b0;
      out_valid_d = 1'b1;
    end
    if (out_hs_c) begin
      out_valid_d = 1'b0;
      in_ready_d  = 1'b1;
    end
  end

  // Data and handshake registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mux_i_q     <= '0;
      cap_q       <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
`ifdef MUX_SCAN_OOR_CHECK_EN
      sticky_q    <= 1'b0;
      oor_q       <= 1'b0;
`endif
    end else begin
      mux_i_q     <= mux_i_d;
      cap_q       <= cap_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
`ifdef MUX_SCAN_OOR_CHECK_EN
      sticky_q    <= sticky_d;
      oor_q       <= oor_d;
`endif
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = cap_q;
  assign bus.mux_i     = mux_i_q;
  assign bus.mux_s     = sel;
  assign busy          = busy_q;
`ifdef MUX_SCAN_OOR_CHECK_EN
  assign oor_err       = oor_q;
`else
  assign oor_err       = 1'b0;
`endif

endmodule : mux_scan_ctrl

// File: tb/tb_mux_scan_ctrl.sv
// Bench for mux_scan_ctrl with a behavioural 10x1 mux in loopback.
// Expected words are queued at each input handshake; a monitor pops and compares
// on every output handshake. Build with or without MUX_SCAN_OOR_CHECK_EN.
module tb_mux_scan_ctrl;

  localparam int unsigned N  = 10;
  localparam int unsigned SW = 4;
`ifdef MUX_SCAN_OOR_CHECK_EN
  localparam int unsigned LAT     = 16;
  localparam int unsigned SEL_TOP = 15;
  localparam logic        OOR_EN  = 1'b1;
`else
  localparam int unsigned LAT     = 10;
  localparam int unsigned SEL_TOP = 9;
  localparam logic        OOR_EN  = 1'b0;
`endif

  typedef struct {
    logic [N-1:0] data;
    logic         oor;
    int unsigned  rise;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic busy;
  logic oor_err;
  logic fault_en = 1'b0;
  logic [SW-1:0] fault_sel = 4'd12;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  int unsigned cyc   = 0;
  logic [SW-1:0] max_sel = '0;
  bit ov_prev = 1'b0;
  exp_t exp_q[$];

  mux_scan_ctrl_if #(.N(N), .SW(SW)) bus ();

  mux_scan_ctrl #(.N(N), .SW(SW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus.master),
    .busy    (busy),
    .oor_err (oor_err)
  );

  // Behavioural 10x1 mux; selects >= N read 0 unless the fault is armed.
  function automatic logic mux_model(logic [N-1:0] d, logic [SW-1:0] s, logic fe,
                                     logic [SW-1:0] fs);
    logic y;
    y = 1'b0;
    if (fe && s == fs) return 1'b1;
    for (int k = 0; k < int'(N); k++) if (s == SW'(k)) y = d[k];
    return y;
  endfunction

  assign bus.mux_y = mux_model(bus.mux_i, bus.mux_s, fault_en, fault_sel);

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: latency on rise, data/oor on every output handshake.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.mux_s > max_sel) max_sel <= bus.mux_s;
      if (bus.out_valid && !ov_prev) begin
        if (exp_q.size() == 0) check("unexpected_out_valid", 32'(bus.out_valid), 32'd0);
        else check("out_valid_latency", cyc, exp_q[0].rise);
      end
      if (bus.out_valid && bus.out_ready && exp_q.size() != 0) begin
        exp_t e;
        e = exp_q.pop_front();
        check("out_data", 32'(bus.out_data), 32'(e.data));
        check("oor_err", 32'(oor_err), 32'(e.oor));
      end
    end
    ov_prev <= bus.out_valid;
  end

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic send(input logic [N-1:0] d, input logic eo);
    int unsigned n;
    exp_t e;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      check("in_ready_timeout", 32'd0, 32'd1);
    end else begin
      e.data = d;
      e.oor  = eo;
      e.rise = cyc + 1 + LAT;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int unsigned n;
    n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      check("drain_timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_in_ready"},  32'(bus.in_ready),  32'd1);
    check({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
    check({tag, "_out_data"},  32'(bus.out_data),  32'd0);
    check({tag, "_mux_i"},     32'(bus.mux_i),     32'd0);
    check({tag, "_mux_s"},     32'(bus.mux_s),     32'd0);
    check({tag, "_busy"},      32'(busy),          32'd0);
    check({tag, "_oor_err"},   32'(oor_err),       32'd0);
  endtask

  initial begin
    logic [N-1:0] w;
    int unsigned n;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_vals("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: single word, select sweep, mux_i stable
    w = 10'b1010101011;
    send(w, 1'b0);
    for (int k = 0; k < int'(LAT); k++) begin
      @(negedge clk);
      check("sweep_mux_s", 32'(bus.mux_s), 32'(k));
      check("sweep_mux_i", 32'(bus.mux_i), 32'(w));
      check("sweep_busy_ready", {30'd0, busy, bus.in_ready}, 32'b10);
    end
    drain();

    // 2: back-to-back with downstream stall
    bus.out_ready = 1'b0;
    fork
      begin
        send(10'h3FF, 1'b0);
        send(10'h000, 1'b0);
      end
      begin
        n = 0;
        @(negedge clk);
        while (!bus.out_valid && n < 100) begin
          @(negedge clk);
          n++;
        end
        for (int i = 0; i < 5; i++) begin
          check("stall_out_valid", 32'(bus.out_valid), 32'd1);
          check("stall_out_data", 32'(bus.out_data), 32'h3FF);
          check("stall_in_ready", 32'(bus.in_ready), 32'd0);
          if (i < 4) @(negedge clk);
        end
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
      end
    join
    drain();

    // 3: async reset mid-scan, then a clean word
    send(10'h155, 1'b0);
    n = 0;
    @(negedge clk);
    while (bus.mux_s != 4'd4 && n < 50) begin
      @(negedge clk);
      n++;
    end
    #2 rst_n = 1'b0;
    #1 check_reset_vals("abort");
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(10'h2AA, 1'b0);
    drain();

    // 4: in_valid pulse while busy is ignored
    send(10'h00F, 1'b0);
    bus.in_valid = 1'b1;
    bus.in_data  = 10'h0F0;
    @(negedge clk);
    check("busy_in_ready", 32'(bus.in_ready), 32'd0);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    drain();
    repeat (20) @(negedge clk);
    check("ignored_no_out", 32'(bus.out_valid), 32'd0);
    check("ignored_mux_i", 32'(bus.mux_i), 32'h00F);
    @(posedge clk);
    #1;

    // 5: faulty mux reads 1 at select 12, then a clean word clears the flag
    fault_en = 1'b1;
    send(10'h1C3, OOR_EN);
    drain();
    fault_en = 1'b0;
    @(negedge clk);
    check("oor_hold", 32'(oor_err), 32'(OOR_EN));
    @(posedge clk);
    #1;
    send(10'h2B4, 1'b0);
    drain();

    // 6: random words, select range
    for (int i = 0; i < 100; i++) begin
      send(10'($urandom_range(0, 1023)), 1'b0);
    end
    drain();
    check("max_mux_s", 32'(max_sel), SEL_TOP);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule : tb_mux_scan_ctrl
